keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven before its rows are sampled (min 2).
REQ-002 Parameter DEBOUNCE, default 8: consecutive identical samples needed to accept a press or a release (min 2).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 row_in  input  4  keypad rows, active-low (pull-ups; low = key closed on the driven column).
REQ-006 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  accepted key, {row[1:0], col[1:0]}; valid while key_held=1.
REQ-008 key_valid  output  1  one-cycle pulse on press acceptance.
REQ-009 key_held  output  1  high from acceptance until release is accepted.
REQ-010 keypad_1, keypad_2, keypad_3, keypad_0  output  1 each  high while the matching key is held; these feed the level-select inputs.
REQ-011 multi_key  output  1  one-cycle pulse when more than one row reads low in a sampled column.

Function
REQ-012 Key map (row,col): '1'=(0,0) code 0, '2'=(0,1) code 1, '3'=(0,2) code 2, '0'=(3,1) code 13; other codes drive no keypad_N line.
REQ-013 All outputs are registered; no output is combinational from row_in.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: the driven column advances 0->1->2->3->0 every SCAN_DIV cycles; row_in is sampled on the last dwell cycle.
REQ-016 SCAN, sample with exactly one row low: latch the candidate {row, col}, freeze col_out, clear the debounce counter, and go to DEBOUNCE.
REQ-017 SCAN, sample with two or more rows low: pulse multi_key, stay in SCAN, and advance the column normally.
REQ-018 DEBOUNCE: each cycle, row_in equal to the latched pattern increments the counter; any other value returns to SCAN at the next column with no output.
REQ-019 DEBOUNCE, counter reaching DEBOUNCE: in the same edge, load key_code, set key_valid=1 for one cycle, set key_held=1 and the mapped keypad_N=1, and go to HELD.
REQ-020 HELD: col_out stays frozen; the first cycle with row_in=4'b1111 enters RELEASE with the counter cleared.
REQ-021 RELEASE: each cycle with row_in=4'b1111 increments the counter; any low row returns to HELD with the counter cleared and no new key_valid.
REQ-022 RELEASE, counter reaching DEBOUNCE: clear key_held and keypad_N, and return to SCAN at the next column after the frozen one.
REQ-023 A second key pressed while in HELD or RELEASE is ignored; no key_valid is issued until release completes.
REQ-024 At most one keypad_N is high at any time; key_valid never fires on consecutive cycles.
REQ-025 Counters saturate, never wrap; width is clog2(max(SCAN_DIV, DEBOUNCE)+1).
REQ-026 Press latency, defaults: key_valid at most 4*SCAN_DIV + DEBOUNCE + 1 cycles after a stable press begins.

Reset
REQ-027 While rst=1 (asynchronous):
- state = SCAN
- col_out = 4'b1110
- key_code = 0
- all counters cleared
- key_valid, key_held, keypad_0..3 and multi_key = 0
REQ-028 rst asserted mid-press or mid-release aborts the operation immediately, with no key_valid pulse; after rst falls, scanning restarts from column 0.

Verification (SCAN_DIV=4, DEBOUNCE=8)
REQ-029 Idle rows 4'b1111 for 64 cycles -> col_out cycles 1110,1101,1011,0111 every 4 clocks; key_valid never asserts.
REQ-030 Press '2' (row0 low on col1) held for 40 cycles -> exactly one key_valid, key_code=1, keypad_2=1 until 8 cycles after release, other keypad_N=0.
REQ-031 Press '1' with a bounce (release for 2 cycles after 3 stable cycles), then stable -> no key_valid during the bounce; one key_valid, key_code=0, after 8 stable cycles.
REQ-032 Rows 0 and 1 low on col2 -> multi_key pulses once per visit to col2, key_valid=0.
REQ-033 '0' held (code 13, keypad_0=1), then '3' added -> keypad_0 stays 1, no new key_valid; both released -> keypad_0 drops after 8 high samples.
REQ-034 rst pulsed during DEBOUNCE of '3' -> all outputs 0 and col_out=1110 in the same cycle; '3' still held after reset -> key_valid with key_code=2.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded-key signal bundle
//
// Purpose: groups the keypad matrix lines and the decoded key outputs of
// keypad_scanner so the scanner and its consumers share one port.
// Signals:
//   row_in     [3:0] keypad rows, active-low (driven by the keypad side)
//   col_out    [3:0] column drive, active-low, one bit low (scanner)
//   key_code   [3:0] accepted key {row[1:0], col[1:0]} (scanner)
//   key_valid        one-cycle pulse on press acceptance (scanner)
//   key_held         high from acceptance until release accepted (scanner)
//   keypad_0..3      high while the matching key is held (scanner)
//   multi_key        one-cycle pulse on a multi-row sample (scanner)
// Modports: master = scanner side, slave = keypad/consumer side.

interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       keypad_0;
  logic       keypad_1;
  logic       keypad_2;
  logic       keypad_3;
  logic       multi_key;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held,
    output keypad_0, keypad_1, keypad_2, keypad_3, multi_key
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held,
    input  keypad_0, keypad_1, keypad_2, keypad_3, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Purpose: drives one keypad column low at a time, samples the rows at the
// end of each column dwell, debounces a single-key press, reports it once,
// and holds the decoded level-select lines until a debounced release.
// Parameters:
//   SCAN_DIV  clock cycles each column is driven before sampling (>= 2)
//   DEBOUNCE  consecutive identical samples to accept press/release (>= 2)
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   kp   keypad_scanner_if.master (row_in in; col_out, key_code, key_valid,
//        key_held, keypad_0..3, multi_key out; all outputs registered)

module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  keypad_scanner_if.master         kp
);

  localparam int MAXV = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [3:0]    pat_q, pat_d;        // row pattern seen at the candidate sample
  logic [3:0]    cand_q, cand_d;      // candidate {row, col}
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    keypad_q, keypad_d;  // bit N drives keypad_N
  logic          multi_key_q, multi_key_d;

  logic [3:0]    row_low;
  logic [2:0]    low_cnt;
  logic [1:0]    row_idx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only four keys feed the level-select lines; everything else maps to none.
  function automatic logic [3:0] keypad_decode(input logic [3:0] code);
    case (code)
      4'd0:    return 4'b0010;  // '1'
      4'd1:    return 4'b0100;  // '2'
      4'd2:    return 4'b1000;  // '3'
      4'd13:   return 4'b0001;  // '0'
      default: return 4'b0000;
    endcase
  endfunction

  // Count the low rows and locate the (only meaningful when single) low row.
  always_comb begin
    row_low = ~kp.row_in;
    low_cnt = 3'd0;
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      low_cnt = low_cnt + {2'b00, row_low[i]};
      if (row_low[i]) row_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    deb_d       = deb_q;
    pat_d       = pat_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    keypad_d    = keypad_q;
    multi_key_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (low_cnt == 3'd1) begin
            // Column stays frozen on the candidate while it is debounced.
            pat_d   = kp.row_in;
            cand_d  = {row_idx, col_q};
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
            if (low_cnt >= 3'd2) multi_key_d = 1'b1;
          end
        end else begin
          div_d = sat_inc(div_q);
        end
      end

      ST_DEBOUNCE: begin
        if (kp.row_in == pat_q) begin
          if (deb_q == DEB_LAST) begin
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            keypad_d    = keypad_decode(cand_q);
            deb_d       = '0;
            state_d     = ST_HELD;
          end else begin
            deb_d = sat_inc(deb_q);
          end
        end else begin
          // Bounce or a different pattern: drop the candidate silently.
          col_d   = col_q + 2'd1;
          div_d   = '0;
          deb_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_HELD: begin
        // Any low row keeps the key held, so extra keys are ignored here.
        if (kp.row_in == 4'b1111) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (kp.row_in == 4'b1111) begin
          if (deb_q == DEB_LAST) begin
            key_held_d = 1'b0;
            keypad_d   = 4'b0000;
            col_d      = col_q + 2'd1;
            div_d      = '0;
            deb_d      = '0;
            state_d    = ST_SCAN;
          end else begin
            deb_d = sat_inc(deb_q);
          end
        end else begin
          deb_d   = '0;
          state_d = ST_HELD;
        end
      end

      default: begin
        col_d   = 2'd0;
        div_d   = '0;
        deb_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      div_q       <= '0;
      deb_q       <= '0;
      pat_q       <= 4'b1111;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      keypad_q    <= 4'b0000;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      pat_q       <= pat_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      keypad_q    <= keypad_d;
      multi_key_q <= multi_key_d;
    end
  end

  // Decoded straight from the column flop, so exactly one bit is low.
  assign kp.col_out   = ~(4'b0001 << col_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.keypad_0  = keypad_q[0];
  assign kp.keypad_1  = keypad_q[1];
  assign kp.keypad_2  = keypad_q[2];
  assign kp.keypad_3  = keypad_q[3];
  assign kp.multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
//
// Purpose: models a 4x4 keypad (pressed[] indexed by {row, col}) driving
// row_in from col_out, applies directed press/bounce/release/reset vectors
// and compares every output against hand-computed cycle-exact values.

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;
  logic [3:0]  row_v;
  int          errors = 0;
  int          checks = 0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low when its column is driven.
  always_comb begin
    row_v = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_out[c]) row_v[r] = 1'b0;
  end
  assign kif.row_in = row_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] kpads();
    return {kif.keypad_3, kif.keypad_2, kif.keypad_1, kif.keypad_0};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_col"},   32'(kif.col_out),   32'(4'b1110));
    check({tag, "_code"},  32'(kif.key_code),  32'(0));
    check({tag, "_valid"}, 32'(kif.key_valid), 32'(0));
    check({tag, "_held"},  32'(kif.key_held),  32'(0));
    check({tag, "_kpads"}, 32'(kpads()),       32'(0));
    check({tag, "_multi"}, 32'(kif.multi_key), 32'(0));
  endtask

  // Holds rst over two edges, checks the reset state, releases at a negedge
  // so the next negedge follows the first active edge.
  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
  endtask

  logic [3:0] exp_col;

  initial begin
    rst     = 1'b1;
    pressed = 16'h0000;

    // Idle scan: col0 until edge 4, then one column per 4 edges.
    reset_dut();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col",   32'(kif.col_out),   32'(exp_col));
      check("idle_valid", 32'(kif.key_valid), 32'(0));
    end

    // '2' (row0,col1): col1 sampled at edge 8, accepted at edge 16.
    pressed = 16'h0002;
    reset_dut();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("k2_valid", 32'(kif.key_valid), 32'(k == 16));
      check("k2_held",  32'(kif.key_held),  32'(k >= 16));
      check("k2_kpads", 32'(kpads()),       32'((k >= 16) ? 4'b0100 : 4'b0000));
      if (k == 16) check("k2_code", 32'(kif.key_code), 32'(1));
    end
    // Release with a 2-edge re-press at edges 5,6: release restarts at edge 7
    // and completes at edge 15, then scanning resumes on col2.
    for (int r = 1; r <= 15; r++) begin
      pressed = (r == 5 || r == 6) ? 16'h0002 : 16'h0000;
      @(negedge clk);
      check("k2r_held",  32'(kif.key_held),  32'(r < 15));
      check("k2r_kpads", 32'(kpads()),       32'((r < 15) ? 4'b0100 : 4'b0000));
      check("k2r_valid", 32'(kif.key_valid), 32'(0));
      if (r == 15) check("k2r_col", 32'(kif.col_out), 32'(4'b1011));
    end

    // '1' (row0,col0) bouncing open at edges 8,9 during debounce: the
    // candidate is dropped, col0 is next sampled at edge 24, accepted at 32.
    pressed = 16'h0001;
    reset_dut();
    for (int k = 1; k <= 40; k++) begin
      pressed = (k == 8 || k == 9) ? 16'h0000 : 16'h0001;
      @(negedge clk);
      check("k1_valid", 32'(kif.key_valid), 32'(k == 32));
      check("k1_held",  32'(kif.key_held),  32'(k >= 32));
      check("k1_kpads", 32'(kpads()),       32'((k >= 32) ? 4'b0010 : 4'b0000));
      if (k == 32) check("k1_code", 32'(kif.key_code), 32'(0));
    end
    pressed = 16'h0000;

    // Rows 0 and 1 low on col2: multi_key at each col2 sample (edge 12 mod 16).
    pressed = 16'h0044;
    reset_dut();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check("mk_multi", 32'(kif.multi_key), 32'((k % 16) == 12));
      check("mk_valid", 32'(kif.key_valid), 32'(0));
      check("mk_held",  32'(kif.key_held),  32'(0));
    end

    // '0' (row3,col1) accepted at edge 16; '3' added later is ignored.
    pressed = 16'h2000;
    reset_dut();
    for (int k = 1; k <= 40; k++) begin
      if (k == 21) pressed = 16'h2004;
      @(negedge clk);
      check("k0_valid", 32'(kif.key_valid), 32'(k == 16));
      check("k0_kpads", 32'(kpads()),       32'((k >= 16) ? 4'b0001 : 4'b0000));
      if (k >= 16) check("k0_code", 32'(kif.key_code), 32'(13));
    end
    pressed = 16'h0000;
    for (int r = 1; r <= 9; r++) begin
      @(negedge clk);
      check("k0r_kpads", 32'(kpads()),      32'((r < 9) ? 4'b0001 : 4'b0000));
      check("k0r_held",  32'(kif.key_held), 32'(r < 9));
    end

    // '3' (row0,col2): reset mid-debounce (after edge 15) aborts at once;
    // after reset the press is re-detected and accepted at edge 20.
    pressed = 16'h0004;
    reset_dut();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("k3_pre_valid", 32'(kif.key_valid), 32'(0));
    end
    check("k3_frozen_col", 32'(kif.col_out), 32'(4'b1011));
    rst = 1'b1;
    #1;
    check_idle_outputs("k3_async");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("k3_valid", 32'(kif.key_valid), 32'(k == 20));
      check("k3_kpads", 32'(kpads()),       32'((k >= 20) ? 4'b1000 : 4'b0000));
      if (k == 20) check("k3_code", 32'(kif.key_code), 32'(2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
